// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM encoding, host command bytes and the
// scancode constants also used by the keyboard receive/decode path.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } tx_state_t;

  // Host-to-device command bytes
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESEND   = 8'hFE;

  // Device-to-host scancodes and responses (scan code set 2)
  localparam logic [7:0] SC_EXTENDED  = 8'hE0;
  localparam logic [7:0] SC_BREAK     = 8'hF0;
  localparam logic [7:0] SC_ACK       = 8'hFA;
  localparam logic [7:0] SC_BAT_OK    = 8'hAA;
  localparam logic [7:0] SC_RESEND    = 8'hFE;
  localparam logic [7:0] SC_ERROR     = 8'hFC;
  localparam logic [7:0] SC_ENTER     = 8'h5A;
  localparam logic [7:0] SC_ESC       = 8'h76;
  localparam logic [7:0] SC_SPACE     = 8'h29;
  localparam logic [7:0] SC_LSHIFT    = 8'h12;
  localparam logic [7:0] SC_RSHIFT    = 8'h59;
  localparam logic [7:0] SC_CAPS      = 8'h58;

  // Index of the parity bit in the 11-bit frame; its falling edge ends SEND
  localparam logic [3:0] PARITY_IDX   = 4'd9;

  function automatic logic odd_parity(input logic [7:0] value);
    return ~^value;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a host controller and the PS/2 transmitter.
interface ps2_host_tx_if;

  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_busy,
    input  tx_done,
    input  tx_err
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_busy,
    output tx_done,
    output tx_err
  );

endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 line with a falling-edge strobe.
// Flops reset high because an idle PS/2 line is pulled up.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync,
  output logic fall
);

  logic meta;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta   <= async_in;
      sync_q <= meta;
      prev_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts a command byte out on device-generated clocks and checks the ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         reset,
  ps2_host_tx_if.slave host,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  tx_state_t        state;
  tx_state_t        state_next;
  logic [INH_W-1:0] inhibit_cnt;
  logic [TMO_W-1:0] timeout_cnt;
  logic [3:0]       bit_idx;
  logic [7:0]       tx_byte;
  logic             tx_parity;
  logic [10:0]      frame;
  logic             frame_bit;
  logic             timeout_hit;
  logic             in_frame;
  logic             send_entry;
  logic             sync_clk;
  logic             clk_fall;
  logic             sync_data;
  logic             data_fall_unused;
  logic             done_int;
  logic             err_int;
  logic             clk_oe_int;
  logic             data_oe_int;

  ps2_sync_edge u_sync_clk (
    .clk      (clk),
    .reset    (reset),
    .async_in (ps2_clk_in),
    .sync     (sync_clk),
    .fall     (clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .clk      (clk),
    .reset    (reset),
    .async_in (ps2_data_in),
    .sync     (sync_data),
    .fall     (data_fall_unused)
  );

  // Frame order on the wire: start(0), D0..D7, parity, stop(1)
  assign frame       = {1'b1, tx_parity, tx_byte, 1'b0};
  assign frame_bit   = (bit_idx <= 4'd10) ? frame[bit_idx] : 1'b1;
  assign timeout_hit = (timeout_cnt == TMO_LAST);
  assign in_frame    = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
  assign send_entry  = (state_next == SEND) && (state != SEND);

  always_comb begin
    state_next  = state;
    done_int    = 1'b0;
    err_int     = 1'b0;
    clk_oe_int  = 1'b0;
    data_oe_int = 1'b0;
    case (state)
      IDLE: begin
        if (host.tx_start) state_next = INHIBIT;
      end
      INHIBIT: begin
        clk_oe_int = 1'b1;
        if (inhibit_cnt == INH_LAST) state_next = REQ;
      end
      REQ: begin
        clk_oe_int  = 1'b1;
        data_oe_int = 1'b1;
        state_next  = SEND;
      end
      SEND: begin
        data_oe_int = ~frame_bit;
        if (timeout_hit) begin
          err_int    = 1'b1;
          state_next = IDLE;
        end else if (clk_fall && (bit_idx == PARITY_IDX)) begin
          state_next = ACK;
        end
      end
      ACK: begin
        if (timeout_hit) begin
          err_int    = 1'b1;
          state_next = IDLE;
        end else if (clk_fall) begin
          if (!sync_data) begin
            state_next = WAIT_IDLE;
          end else begin
            err_int    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (timeout_hit) begin
          err_int    = 1'b1;
          state_next = IDLE;
        end else if (sync_clk && sync_data) begin
          done_int   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The frame timer runs across SEND, ACK and WAIT_IDLE so it bounds the
  // whole transaction; the inhibit counter restarts on any state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      inhibit_cnt <= '0;
      timeout_cnt <= '0;
      bit_idx     <= '0;
      tx_byte     <= '0;
      tx_parity   <= 1'b0;
    end else begin
      state <= state_next;

      if (state_next != state)
        inhibit_cnt <= '0;
      else if (state == INHIBIT)
        inhibit_cnt <= inhibit_cnt + 1'b1;

      if (send_entry || (state_next == IDLE))
        timeout_cnt <= '0;
      else if (in_frame)
        timeout_cnt <= timeout_cnt + 1'b1;

      if (send_entry || (state_next == IDLE))
        bit_idx <= '0;
      else if ((state == SEND) && clk_fall)
        bit_idx <= bit_idx + 4'd1;

      if ((state == IDLE) && host.tx_start) begin
        tx_byte   <= host.tx_data;
        tx_parity <= odd_parity(host.tx_data);
      end
    end
  end

  assign ps2_clk_oe   = clk_oe_int;
  assign ps2_data_oe  = data_oe_int;
  assign host.tx_busy = (state != IDLE);
  assign host.tx_done = done_int & ~reset;
  assign host.tx_err  = err_int & ~reset;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

  localparam int INHIBIT = 5000;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 10;
  localparam int LIMIT   = 20000;

  logic clk;
  logic reset;
  logic ps2_clk_oe;
  logic ps2_data_oe;
  logic dev_clk_low;
  logic dev_data_low;
  logic ps2_clk_line;
  logic ps2_data_line;

  int check_count = 0;
  int fail_count  = 0;

  int done_total       = 0;
  int err_total        = 0;
  int overlap_total    = 0;
  int busy_late_total  = 0;
  int clk_low_run      = 0;
  int last_clk_low_run = 0;
  logic pulse_prev     = 1'b0;

  ps2_host_tx_if host_bus ();

  ps2_host_tx #(
    .INHIBIT_CYCLES (INHIBIT),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .host        (host_bus),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse bookkeeping and host clock-low run length, sampled mid-cycle
  always @(negedge clk) begin
    if (host_bus.tx_done) done_total++;
    if (host_bus.tx_err) err_total++;
    if (host_bus.tx_done && host_bus.tx_err) overlap_total++;
    if (pulse_prev && host_bus.tx_busy) busy_late_total++;
    pulse_prev = host_bus.tx_done | host_bus.tx_err;
    if (ps2_clk_oe) begin
      clk_low_run++;
    end else begin
      if (clk_low_run != 0) last_clk_low_run = clk_low_run;
      clk_low_run = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    @(negedge clk);
    host_bus.tx_start = 1'b1;
    host_bus.tx_data  = data;
    @(negedge clk);
    host_bus.tx_start = 1'b0;
  endtask

  // Device side: wait for request-to-send, then clock out up to max_edges
  // falling edges, sampling the host data line during each high phase.
  task automatic deviceFrame(input bit ack, input int max_edges,
                             output logic [10:0] bits);
    int guard;
    bits  = '0;
    guard = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && guard < LIMIT) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("rts_seen", guard < LIMIT, 1'b1);
    if (guard >= LIMIT) return;
    repeat (HALF) @(negedge clk);
    bits[0] = ps2_data_line;
    for (int e = 1; e <= 11 && e <= max_edges; e++) begin
      if (e == 11) begin
        dev_data_low = ack;
        repeat (2) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
      if (e <= 10) bits[e] = ps2_data_line;
    end
    dev_data_low = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int g;
    g = 0;
    while (host_bus.tx_busy && g < budget) begin
      @(negedge clk);
      g++;
    end
    checkOutput("busy_clears", host_bus.tx_busy, 1'b0);
  endtask

  initial begin
    logic [10:0] bits;
    int done0;
    int err0;
    int n;
    int g;

    reset             = 1'b1;
    host_bus.tx_start = 1'b0;
    host_bus.tx_data  = 8'h00;
    dev_clk_low       = 1'b0;
    dev_data_low      = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_clk_oe", ps2_clk_oe, 1'b0);
    checkOutput("rst_data_oe", ps2_data_oe, 1'b0);
    checkOutput("rst_busy", host_bus.tx_busy, 1'b0);
    checkOutput("rst_pulses", {host_bus.tx_done, host_bus.tx_err}, 2'b00);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] set-LEDs 0xED with ACK");
    done0 = done_total; err0 = err_total;
    applyStimulus(8'hED);
    checkOutput("ed_busy", host_bus.tx_busy, 1'b1);
    deviceFrame(1'b1, 11, bits);
    checkOutput("ed_start", bits[0], 1'b0);
    checkOutput("ed_data", bits[8:1], 8'hED);
    checkOutput("ed_parity", bits[9], 1'b1);
    checkOutput("ed_stop", bits[10], 1'b1);
    waitIdle(200);
    checkOutput("ed_done", done_total - done0, 1);
    checkOutput("ed_err", err_total - err0, 0);
    checkOutput("ed_clk_low", last_clk_low_run, INHIBIT + 1);

    $display("[TB] enable 0xF4 with ACK");
    done0 = done_total;
    applyStimulus(8'hF4);
    deviceFrame(1'b1, 11, bits);
    checkOutput("f4_data", bits[8:1], 8'hF4);
    checkOutput("f4_parity", bits[9], 1'b0);
    checkOutput("f4_clk_low", last_clk_low_run, INHIBIT + 1);
    waitIdle(200);
    checkOutput("f4_done", done_total - done0, 1);

    $display("[TB] resend 0xFE, device withholds ACK");
    done0 = done_total; err0 = err_total;
    applyStimulus(8'hFE);
    deviceFrame(1'b0, 11, bits);
    checkOutput("nack_data", bits[8:1], 8'hFE);
    waitIdle(200);
    checkOutput("nack_err", err_total - err0, 1);
    checkOutput("nack_done", done_total - done0, 0);
    checkOutput("nack_clk_oe", ps2_clk_oe, 1'b0);
    checkOutput("nack_data_oe", ps2_data_oe, 1'b0);

    $display("[TB] silent device, frame timeout");
    done0 = done_total;
    applyStimulus(8'hED);
    g = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && g < LIMIT) begin
      @(negedge clk);
      g++;
    end
    checkOutput("tmo_send_seen", g < LIMIT, 1'b1);
    n = 1;
    while (!host_bus.tx_err && n < TIMEOUT + 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tmo_cycles", n, TIMEOUT);
    @(negedge clk);
    checkOutput("tmo_clk_oe", ps2_clk_oe, 1'b0);
    checkOutput("tmo_data_oe", ps2_data_oe, 1'b0);
    checkOutput("tmo_busy", host_bus.tx_busy, 1'b0);
    checkOutput("tmo_done", done_total - done0, 0);

    $display("[TB] reset 0xFF with a competing 0x00 request");
    done0 = done_total;
    applyStimulus(8'hFF);
    repeat (50) @(negedge clk);
    applyStimulus(8'h00);
    deviceFrame(1'b1, 11, bits);
    checkOutput("ff_data", bits[8:1], 8'hFF);
    checkOutput("ff_parity", bits[9], 1'b1);
    waitIdle(200);
    checkOutput("ff_done", done_total - done0, 1);

    $display("[TB] reset after edge 5");
    applyStimulus(8'hED);
    deviceFrame(1'b1, 5, bits);
    checkOutput("mid_busy", host_bus.tx_busy, 1'b1);
    done0 = done_total; err0 = err_total;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_clk_oe", ps2_clk_oe, 1'b0);
    checkOutput("mid_data_oe", ps2_data_oe, 1'b0);
    checkOutput("mid_busy_low", host_bus.tx_busy, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("mid_pulses", (done_total - done0) + (err_total - err0), 0);

    $display("[TB] 0xED after mid-frame reset");
    done0 = done_total; err0 = err_total;
    applyStimulus(8'hED);
    deviceFrame(1'b1, 11, bits);
    checkOutput("again_data", bits[8:1], 8'hED);
    checkOutput("again_parity", bits[9], 1'b1);
    waitIdle(200);
    checkOutput("again_done", done_total - done0, 1);
    checkOutput("again_err", err_total - err0, 0);

    repeat (3) @(negedge clk);
    checkOutput("pulse_overlap", overlap_total, 0);
    checkOutput("busy_after_pulse", busy_late_total, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000: clock-low inhibit time in clk cycles (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: maximum frame duration in clk cycles (20 ms at 50 MHz).
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 tx_start  input  1  one-cycle request to send tx_data.
REQ-006 tx_data  input  8  command byte, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
REQ-007 ps2_clk_in  input  1  raw PS2 clock line, asynchronous.
REQ-008 ps2_data_in  input  1  raw PS2 data line, asynchronous.
REQ-009 ps2_clk_oe  output  1  1 = drive PS2 clock low; 0 = release (pull-up).
REQ-010 ps2_data_oe  output  1  1 = drive PS2 data low; 0 = release.
REQ-011 tx_busy  output  1  high from accepted tx_start until return to IDLE.
REQ-012 tx_done  output  1  one-cycle pulse on acknowledged frame completion.
REQ-013 tx_err  output  1  one-cycle pulse on missing ACK or timeout.

Function
REQ-014 ps2_clk_in and ps2_data_in SHALL pass a 2-FF synchronizer; a PS2 falling edge SHALL be sync_clk 1 to 0 between consecutive clk cycles.
REQ-015 States SHALL be IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE.
REQ-016 IDLE: both oe low, tx_busy low; tx_start SHALL latch tx_data, compute odd parity (parity = ~^tx_data), go INHIBIT.
REQ-017 tx_start while tx_busy is high SHALL be ignored, with no effect on the latched byte.
REQ-018 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles, then go REQ.
REQ-019 REQ: ps2_clk_oe=1 and ps2_data_oe=1 for exactly 1 cycle, then go SEND with bit index 0.
REQ-020 SEND: ps2_clk_oe=0; ps2_data_oe holds start bit (low) until the first falling edge.
REQ-021 On falling edges 1..8, data SHALL present D0..D7 LSB first; edge 9 parity; edge 10 stop bit (release line); ps2_data_oe = NOT bit value.
REQ-022 After edge 10 go ACK; on the next falling edge sample sync_data: 0 means ACK, go WAIT_IDLE; 1 means tx_err pulse, go IDLE.
REQ-023 WAIT_IDLE: when sync_clk=1 and sync_data=1, pulse tx_done and go IDLE.
REQ-024 A timeout counter SHALL start on entry to SEND; reaching TIMEOUT_CYCLES in SEND, ACK or WAIT_IDLE SHALL release both lines, pulse tx_err, go IDLE.
REQ-025 tx_done and tx_err SHALL never assert in the same cycle; tx_busy SHALL drop in the cycle after either pulse.
REQ-026 Counters SHALL be sized by $clog2 of their parameter, saturate-free, cleared on every state entry.

Reset
REQ-027 With reset high at a clk edge: state IDLE; ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err all 0; counters, bit index, latched byte 0.
REQ-028 Reset mid-frame SHALL release both lines on the next clk edge with no tx_err or tx_done pulse.

Structure
REQ-029 Package ps2_pkg SHALL hold the state encoding, PS2 command constants (0xED, 0xFF, 0xF4, 0xFE) and the scancode constants shared with the keyboard decoder.
REQ-030 Sub-module ps2_sync_edge (2-FF synchronizer plus falling-edge detect) SHALL be instantiated here and SHALL be reusable by the receive path.

Verification
REQ-031 tx_start with 0xED, device model ACKs -> bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done pulses once; tx_err stays 0.
REQ-032 tx_start with 0xF4 -> parity bit 0; ps2_clk_oe low-time equal to 5000+1 cycles before release.
REQ-033 Device leaves data high on the 11th edge -> tx_err pulse, tx_done 0, both oe 0, tx_busy drops next cycle.
REQ-034 Device never clocks after REQ -> tx_err exactly TIMEOUT_CYCLES cycles after SEND entry; lines released.
REQ-035 Second tx_start (0x00) during a 0xFF frame -> ignored; bits sent are 0xFF, parity 1.
REQ-036 reset asserted after edge 5 of a frame -> next cycle both oe 0, tx_busy 0, no pulses; a new 0xED send completes normally.
